// File: rtl/ram_access_arbiter_if.sv
// ram_access_arbiter_if: bundled core request lines and shared 1-bit RAM port
interface ram_access_arbiter_if #(
    parameter int ADDR_W    = 14,
    parameter int FETCH_LEN = 17
);
    logic [3:0]           req;
    logic [3:0]           we;
    logic [3:0]           fetch;
    logic [3:0]           wdata;
    logic [ADDR_W-1:0]    addr0;
    logic [ADDR_W-1:0]    addr1;
    logic [ADDR_W-1:0]    addr2;
    logic [ADDR_W-1:0]    addr3;
    logic                 mem_dataout;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_store;
    logic                 mem_datain;
    logic [3:0]           ack;
    logic                 rdata;
    logic [FETCH_LEN-1:0] fetch_data;
    logic                 busy;
    logic [1:0]           grant_id;

    modport master (
        output req, we, fetch, wdata, addr0, addr1, addr2, addr3, mem_dataout,
        input  mem_addr, mem_store, mem_datain, ack, rdata, fetch_data, busy, grant_id
    );

    modport slave (
        input  req, we, fetch, wdata, addr0, addr1, addr2, addr3, mem_dataout,
        output mem_addr, mem_store, mem_datain, ack, rdata, fetch_data, busy, grant_id
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin arbiter giving four cores single-bit or burst access to a 1-bit RAM
// Burst (FETCH) support is built only when RAM_ARB_FETCH_EN is defined.
module ram_access_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int FETCH_LEN = 17
) (
    input logic                  clk,
    input logic                  clear,
    ram_access_arbiter_if.slave  bus
);
    localparam int KW = (FETCH_LEN > 1) ? $clog2(FETCH_LEN) : 1;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] FETCH  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        grant_q, grant_d;
    logic              rdata_q, rdata_d;
    logic [1:0]        pick;
    logic [ADDR_W-1:0] addr_g;
    logic [ADDR_W-1:0] addr_off;
    logic              we_g;
    logic              go_fetch;
    logic              fetch_last;

    // Scan downward so the nearest requester after last_grant is the last to overwrite pick.
    always_comb begin
        pick = last_q;
        for (int i = 4; i >= 1; i--)
            if (bus.req[last_q + 2'(i)]) pick = last_q + 2'(i);
    end

    assign addr_g = (grant_q == 2'd0) ? bus.addr0 :
                    (grant_q == 2'd1) ? bus.addr1 :
                    (grant_q == 2'd2) ? bus.addr2 : bus.addr3;
    assign we_g   = bus.we[grant_q];

`ifdef RAM_ARB_FETCH_EN
    logic [KW-1:0]        k_q, k_d;
    logic [FETCH_LEN-1:0] fetch_q, fetch_d;

    assign k_d     = (state_q == FETCH) ? k_q + 1'b1 : '0;
    assign fetch_d = (state_q == FETCH) ? {fetch_q[FETCH_LEN-2:0], bus.mem_dataout} : fetch_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            k_q     <= '0;
            fetch_q <= '0;
        end else begin
            k_q     <= k_d;
            fetch_q <= fetch_d;
        end
    end

    assign fetch_last     = (k_q == KW'(FETCH_LEN - 1));
    assign go_fetch       = bus.fetch[pick] & ~bus.we[pick];
    assign addr_off       = ADDR_W'(k_q);
    assign bus.fetch_data = fetch_q;
`else
    logic unused_fetch;

    assign unused_fetch   = ^bus.fetch;
    assign fetch_last     = 1'b1;
    assign go_fetch       = 1'b0;
    assign addr_off       = '0;
    assign bus.fetch_data = '0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (|bus.req) begin
                grant_d = pick;
                last_d  = pick;
                state_d = go_fetch ? FETCH : ACCESS;
            end
            ACCESS: begin
                rdata_d = we_g ? rdata_q : bus.mem_dataout;
                state_d = DONE;
            end
            FETCH:   state_d = fetch_last ? DONE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            grant_q <= 2'd0;
            rdata_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            rdata_q <= rdata_d;
        end
    end

    // clear is gated in combinationally so an aborted write never reaches the RAM edge.
    assign bus.mem_addr   = (state_q == ACCESS || state_q == FETCH) ? addr_g + addr_off : '0;
    assign bus.mem_store  = (state_q == ACCESS) && we_g && !clear;
    assign bus.mem_datain = (state_q == ACCESS && we_g) ? bus.wdata[grant_q] : 1'b0;
    assign bus.ack        = (state_q == DONE && !clear) ? (4'b0001 << grant_q) : 4'b0000;
    assign bus.rdata      = rdata_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.grant_id   = grant_q;
endmodule
